// File: rtl/conv2d_layer_if.sv
// Stream/control bundle for conv2d_layer: weight/pixel input side and
// per-channel result side.
interface conv2d_layer_if #(
    parameter int N_OUT = 4
);
    logic                   load;
    logic                   input_valid;
    logic                   sof;
    logic [31:0]            d_in;
    logic                   load_success;
    logic                   output_valid;
    logic                   o_sof;
    logic [N_OUT-1:0][31:0] d_out;

    modport master (
        output load, input_valid, sof, d_in,
        input  load_success, output_valid, o_sof, d_out
    );

    modport slave (
        input  load, input_valid, sof, d_in,
        output load_success, output_valid, o_sof, d_out
    );
endinterface

// File: rtl/conv2d_layer.sv
// 3x3 streaming convolution: N_OUT channels share one line buffer, weights and biases
// loaded over d_in. Define CONV2D_LAYER_SAT_EN to saturate the sum instead of wrapping.
module conv2d_layer #(
    parameter int N_OUT  = 4,
    parameter int IN_W   = 64,
    parameter int IN_H   = 64,
    parameter int STRIDE = 2,
    parameter int RELU   = 1,
    parameter int FRAC   = 16
) (
    input logic           clk,
    input logic           rst,
    conv2d_layer_if.slave bus
);
    localparam int N_WORDS = N_OUT * 10;
    localparam int WCW     = $clog2(N_WORDS);
    localparam int CW      = $clog2(IN_W);
    localparam int RW      = $clog2(IN_H);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state, state_nx;

    logic [WCW-1:0]     wcnt;
    logic signed [31:0] coef [N_WORDS];
    logic               take_word, last_word, take_pix;

    always_comb begin
        take_word = (state == LOAD) && bus.input_valid && !bus.load;
        last_word = take_word && (wcnt == WCW'(N_WORDS - 1));
        state_nx  = state;
        if (bus.load)
            state_nx = LOAD;
        else if (last_word)
            state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            if (bus.load || last_word)
                wcnt <= '0;
            else if (take_word)
                wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take_word)
            coef[wcnt] <= bus.d_in;
    end

    assign bus.load_success = (state == RUN);

    // Stage 0: register the accepted pixel with its raster position.
    logic               active, emit;
    logic [CW-1:0]      col, pcol, col0;
    logic [RW-1:0]      row, prow;
    logic               v0, e0, s0;
    logic signed [31:0] pix0;

    always_comb begin
        take_pix = (state == RUN) && bus.input_valid && !bus.load && (bus.sof || active);
        pcol     = bus.sof ? '0 : col;
        prow     = bus.sof ? '0 : row;
        emit     = (int'(prow) >= 2) && (int'(pcol) >= 2) &&
                   ((int'(prow) - 2) % STRIDE == 0) && ((int'(pcol) - 2) % STRIDE == 0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            active <= 1'b0;
            col    <= '0;
            row    <= '0;
            v0     <= 1'b0;
            e0     <= 1'b0;
            s0     <= 1'b0;
        end else begin
            v0 <= take_pix;
            e0 <= take_pix && emit;
            s0 <= take_pix && emit && (prow == RW'(2)) && (pcol == CW'(2));
            if (state != RUN)
                active <= 1'b0;
            if (take_pix) begin
                active <= 1'b1;
                if (pcol == CW'(IN_W - 1)) begin
                    col <= '0;
                    if (prow == RW'(IN_H - 1)) begin
                        row    <= '0;
                        active <= 1'b0;
                    end else begin
                        row <= prow + 1'b1;
                    end
                end else begin
                    col <= pcol + 1'b1;
                    row <= prow;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_pix) begin
            pix0 <= bus.d_in;
            col0 <= pcol;
        end
    end

    // Stage 1: line buffer rotate and 3x3 window shift.
    logic signed [31:0] lb0 [IN_W];
    logic signed [31:0] lb1 [IN_W];
    logic signed [31:0] win [3][3];
    logic               v1, s1;

    always_ff @(posedge clk) begin
        if (v0) begin
            lb0[col0] <= lb1[col0];
            lb1[col0] <= pix0;
            for (int unsigned i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb0[col0];
            win[1][2] <= lb1[col0];
            win[2][2] <= pix0;
        end
    end

    // Stage 2: shifted products, truncated to the 40-bit accumulator width.
    logic signed [39:0] prod_c [N_OUT][9];
    logic signed [39:0] prod   [N_OUT][9];
    logic               v2, s2;

    always_comb begin
        prod_c = '{default: '0};
        for (int unsigned ch = 0; ch < N_OUT; ch++)
            for (int unsigned k = 0; k < 9; k++)
                prod_c[ch][k] = 40'((64'(win[k/3][k%3]) * 64'(coef[ch*10+k])) >>> FRAC);
    end

    always_ff @(posedge clk) begin
        if (v1)
            prod <= prod_c;
    end

    // Stage 3: bias + sum, width reduction, ReLU.
    logic signed [39:0] sum_c [N_OUT];
    logic signed [31:0] res_c [N_OUT];
`ifdef CONV2D_LAYER_SAT_EN
    localparam logic signed [39:0] SAT_HI = 40'sh007FFFFFFF;
    localparam logic signed [39:0] SAT_LO = -40'sh0080000000;
`endif

    always_comb begin
        sum_c = '{default: '0};
        res_c = '{default: '0};
        for (int unsigned ch = 0; ch < N_OUT; ch++) begin
            sum_c[ch] = 40'(coef[ch*10+9]);
            for (int unsigned k = 0; k < 9; k++)
                sum_c[ch] = sum_c[ch] + prod[ch][k];
`ifdef CONV2D_LAYER_SAT_EN
            if (sum_c[ch] > SAT_HI)
                res_c[ch] = 32'sh7FFFFFFF;
            else if (sum_c[ch] < SAT_LO)
                res_c[ch] = 32'sh80000000;
            else
                res_c[ch] = 32'(sum_c[ch]);
`else
            res_c[ch] = 32'(sum_c[ch]);
`endif
            if (RELU != 0 && res_c[ch][31])
                res_c[ch] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1               <= 1'b0;
            s1               <= 1'b0;
            v2               <= 1'b0;
            s2               <= 1'b0;
            bus.output_valid <= 1'b0;
            bus.o_sof        <= 1'b0;
            bus.d_out        <= '0;
        end else begin
            v1               <= e0 && !bus.load;
            s1               <= s0 && !bus.load;
            v2               <= v1 && !bus.load;
            s2               <= s1 && !bus.load;
            bus.output_valid <= v2 && !bus.load;
            bus.o_sof        <= s2 && v2 && !bus.load;
            if (v2 && !bus.load)
                for (int unsigned ch = 0; ch < N_OUT; ch++)
                    bus.d_out[ch] <= res_c[ch];
        end
    end
endmodule
